sv_literal_parser: RTL and testbench
====================================

// Module: sv_literal_parser
// PURPOSE
//  Reads a SystemVerilog numeric literal as an ASCII byte stream (e.g. "32'h8", "2", "32'b1") and returns
//  its value, size and base, cast to a selected localparam data type (bit/logic/reg/byte/shortint/int/
//  longint/integer/time). It is the reader for the constant tables the team writes in packages. It sits
//  between the token front-end and the constant-evaluation stage.
// PARAMETERS
//  VAL_W    64  width of the value accumulator and out_value (>= 64)
//  SIZE_W   16  width of the parsed size field; sizes >= 2**SIZE_W give an overflow error
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       asynchronous active-low reset
//  in_valid    in   1       input byte valid
//  in_ready    out  1       parser can accept a byte
//  in_data     in   8       ASCII character
//  in_last     in   1       marks the final byte of the literal token
//  type_code   in   4       target type (sv_lit_pkg::type_e); sampled with the first byte of a token
//  out_valid   out  1       result valid
//  out_ready   in   1       consumer accepts the result
//  out_value   out  VAL_W   value after the type cast
//  out_size    out  SIZE_W  explicit size; 0 for an unsized literal
//  out_base    out  2       DEC=0, BIN=1, OCT=2, HEX=3
//  out_trunc   out  1       the cast or size masking discarded nonzero bits
//  out_err     out  3       0 none, 1 bad char, 2 missing digits, 3 zero size, 4 overflow
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0 except in_ready=0 during reset and 1 after reset.
//    Reset mid-token discards the partial token.
//  - FSM states: IDLE -> LEAD -> BASE -> DIGITS -> OUT -> IDLE.
//    - IDLE: a digit enters LEAD. A ' enters BASE as an unsized-based literal.
//    - LEAD: accumulates decimal digits and '_'. A ' moves to BASE and turns the accumulated value into the size.
//    - BASE: accepts b/B, o/O, h/H or d/D, with an optional s/S before it (ignored). Any other char is error 1.
//    - DIGITS: accumulates digits of the chosen base, skipping '_'. Hex digits are case-insensitive.
//  - Byte handshake: one byte is accepted per cycle when in_valid && in_ready.
//    in_ready = 1 in every state except OUT.
//  - An accepted byte with in_last=1 moves the FSM to OUT on the next edge. out_valid rises 1 cycle after the last byte.
//  - OUT holds out_* stable until out_valid && out_ready, then returns to IDLE with in_ready=1 in the next cycle.
//    No bubble beyond that.
//  - After an error, further bytes are consumed and ignored until in_last. The first error code wins.
//    out_value is 0 when out_err != 0.
//  - Accumulation arithmetic:
//    - DEC: v = v*10 + d. BIN: v<<1|d. OCT: v<<3|d. HEX: v<<4|d.
//    - Any bit shifted out of VAL_W gives error 4.
//    - x/z/?, a digit invalid for the base, or a second ' give error 1.
//  - Completion checks, in this order:
//    - in_last in BASE, or a ' followed by no digits: error 2.
//    - Size 0: error 3.
//    - Sized literal: the value is masked to out_size bits; out_trunc=1 if set bits were dropped.
//  - Cast by type_code, via the sv_lit_pkg width/sign table:
//    - IMPLICIT: unchanged.
//    - BIT/LOGIC/REG: 1 bit.
//    - BYTE 8, SHORTINT 16, INT 32, INTEGER 32: signed, sign-extended to VAL_W.
//    - LONGINT 64: signed. TIME 64: unsigned.
//    - out_trunc is also set when the cast drops nonzero bits.
//  - Simultaneous in_last and an error on the same byte: the error is reported and the FSM still goes to OUT.
// STRUCTURE
//  - sv_lit_pkg (shared): base_e, type_e, err_e enums; function type_width(type_e) and type_signed(type_e).
//  - Sub-module sv_lit_cast: combinational mask/truncate/sign-extend plus trunc flag. Shared by future
//    writer blocks.
// TESTING
//  - "32'h8", INT -> value 8, size 32, base HEX, trunc 0, err 0; out_valid 1 cycle after last byte.
//  - "2", BIT -> value 0, size 0, base DEC, trunc 1, err 0.
//  - "32'o5", BYTE, with out_ready held low 5 cycles -> outputs stable; in_ready=0 until the handshake.
//  - "8'hFF", BYTE -> value all-ones (sign-extended), trunc 0. "4'hFF", IMPLICIT -> value 0xF, trunc 1.
//  - Error cases:
//    - "32'" -> err 2.
//    - "32'q1" -> err 1.
//    - "0'b1" -> err 3.
//    - 21 decimal '9's (VAL_W=64) -> err 4.
//  - rst_n pulsed low after "32'" -> out_valid 0. The next token "32'b1", TIME parses to value 1.

Source files
------------

// File: rtl/sv_lit_pkg.sv
// Shared enums and type tables for SystemVerilog numeric literal readers and writers.
package sv_lit_pkg;

   typedef enum logic [1:0] {BASE_DEC, BASE_BIN, BASE_OCT, BASE_HEX} base_e;

   typedef enum logic [3:0] {
      TYPE_IMPLICIT, TYPE_BIT, TYPE_LOGIC, TYPE_REG, TYPE_BYTE,
      TYPE_SHORTINT, TYPE_INT, TYPE_LONGINT, TYPE_INTEGER, TYPE_TIME
   } type_e;

   typedef enum logic [2:0] {ERR_NONE, ERR_CHAR, ERR_DIGITS, ERR_ZERO, ERR_OVF} err_e;

   typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_BASE, ST_DIGITS, ST_OUT} state_e;

   // Width 0 means "no cast": the value keeps the full accumulator width.
   function automatic int type_width(input type_e t);
      case (t)
         TYPE_BIT, TYPE_LOGIC, TYPE_REG: return 1;
         TYPE_BYTE:                      return 8;
         TYPE_SHORTINT:                  return 16;
         TYPE_INT, TYPE_INTEGER:         return 32;
         TYPE_LONGINT, TYPE_TIME:        return 64;
         default:                        return 0;
      endcase
   endfunction

   function automatic logic type_signed(input type_e t);
      case (t)
         TYPE_BYTE, TYPE_SHORTINT, TYPE_INT, TYPE_INTEGER, TYPE_LONGINT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Returns 0..15 for a hex digit (either case), 16 for anything else.
   function automatic logic [4:0] digit_value(input logic [7:0] c);
      if (c >= "0" && c <= "9")      return 5'(c - "0");
      else if (c >= "a" && c <= "f") return 5'(c - "a" + 8'd10);
      else if (c >= "A" && c <= "F") return 5'(c - "A" + 8'd10);
      else                           return 5'd16;
   endfunction

endpackage

// File: rtl/sv_lit_cast.sv
// Combinational cast of an accumulated literal value to a target data type.
module sv_lit_cast import sv_lit_pkg::*; #(
   parameter int VAL_W = 64
) (
   input  logic [VAL_W-1:0] value,
   input  type_e            type_code,
   output logic [VAL_W-1:0] result,
   output logic             trunc
);

   int               w;
   logic [VAL_W-1:0] mask;
   logic [VAL_W-1:0] msb;

   always_comb begin
      w = type_width(type_code);
      if (w == 0 || w >= VAL_W) mask = '1;
      else                      mask = {VAL_W{1'b1}} >> (VAL_W - w);
      msb    = mask & ~(mask >> 1);
      trunc  = |(value & ~mask);
      result = value & mask;
      if (type_signed(type_code) && |(value & msb)) result = result | ~mask;
   end

endmodule

// File: rtl/sv_literal_parser.sv
// Streaming reader for SystemVerilog numeric literals: size, base, value, then a type cast.
module sv_literal_parser import sv_lit_pkg::*; #(
   parameter int VAL_W  = 64,
   parameter int SIZE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   input  logic [3:0]        type_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VAL_W-1:0]  out_value,
   output logic [SIZE_W-1:0] out_size,
   output logic [1:0]        out_base,
   output logic              out_trunc,
   output logic [2:0]        out_err
);

   // Handshakes: a byte transfers on a rising edge with in_valid && in_ready; a result
   // transfers with out_valid && out_ready. Outputs hold stable while out_valid && !out_ready.
   localparam logic [7:0] TICK = 8'h27;

   state_e              state, st_n;
   logic [VAL_W-1:0]    acc, acc_n, acc_shift;
   logic [SIZE_W-1:0]   size_q, size_n;
   logic                sized_q, sized_n, dig_q, dig_n, sgn_q, sgn_n, acc_ovf;
   base_e               base_q, base_n;
   err_e                err_q, err_n, fin_err;
   type_e               type_q, type_n;
   logic [4:0]          dval, radix;
   logic [7:0]          lc;
   logic [VAL_W+3:0]    dec_prod;
   logic [VAL_W-1:0]    size_mask, pre_val, cast_val;
   logic                size_trunc, cast_trunc, accept;

   assign accept   = in_valid && in_ready;
   assign dval     = digit_value(in_data);
   assign lc       = in_data | 8'h20;
   assign dec_prod = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + (VAL_W+4)'(dval);

   always_comb begin
      radix     = 5'd10;
      acc_ovf   = |dec_prod[VAL_W+3:VAL_W];
      acc_shift = dec_prod[VAL_W-1:0];
      case (base_q)
         BASE_BIN: begin radix = 5'd2;  acc_ovf = acc[VAL_W-1];
                         acc_shift = {acc[VAL_W-2:0], dval[0]}; end
         BASE_OCT: begin radix = 5'd8;  acc_ovf = |acc[VAL_W-1:VAL_W-3];
                         acc_shift = {acc[VAL_W-4:0], dval[2:0]}; end
         BASE_HEX: begin radix = 5'd16; acc_ovf = |acc[VAL_W-1:VAL_W-4];
                         acc_shift = {acc[VAL_W-5:0], dval[3:0]}; end
         default: ;
      endcase
   end

   // Next token context after consuming the current byte; IDLE starts from a clean slate.
   always_comb begin
      st_n = state; acc_n = acc; size_n = size_q; sized_n = sized_q; base_n = base_q;
      err_n = err_q; dig_n = dig_q; sgn_n = sgn_q; type_n = type_q;
      if (state == ST_IDLE) begin
         acc_n = '0; size_n = '0; sized_n = 1'b0; base_n = BASE_DEC; err_n = ERR_NONE;
         dig_n = 1'b0; sgn_n = 1'b0; type_n = type_e'(type_code);
      end
      if (err_n == ERR_NONE) begin
         case (state)
            ST_IDLE: begin
               if (dval < 5'd10) begin acc_n = VAL_W'(dval); st_n = ST_LEAD; end
               else if (in_data == TICK) st_n = ST_BASE;
               else begin err_n = ERR_CHAR; st_n = ST_DIGITS; end
            end
            ST_LEAD: begin
               if (dval < 5'd10) begin
                  if (acc_ovf) err_n = ERR_OVF;
                  else         acc_n = acc_shift;
               end else if (in_data == TICK) begin
                  if (|(acc >> SIZE_W)) err_n = ERR_OVF;
                  else begin
                     size_n = acc[SIZE_W-1:0]; sized_n = 1'b1; acc_n = '0; st_n = ST_BASE;
                  end
               end else if (in_data != "_") err_n = ERR_CHAR;
            end
            ST_BASE: begin
               case (lc)
                  "s":     if (sgn_q) err_n = ERR_CHAR; else sgn_n = 1'b1;
                  "b":     begin base_n = BASE_BIN; st_n = ST_DIGITS; end
                  "o":     begin base_n = BASE_OCT; st_n = ST_DIGITS; end
                  "h":     begin base_n = BASE_HEX; st_n = ST_DIGITS; end
                  "d":     begin base_n = BASE_DEC; st_n = ST_DIGITS; end
                  default: err_n = ERR_CHAR;
               endcase
            end
            ST_DIGITS: begin
               if (in_data != "_") begin
                  if (dval >= radix) err_n = ERR_CHAR;
                  else if (acc_ovf)  err_n = ERR_OVF;
                  else begin acc_n = acc_shift; dig_n = 1'b1; end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      fin_err = err_n;
      if (err_n == ERR_NONE) begin
         if (st_n == ST_BASE || (st_n == ST_DIGITS && !dig_n)) fin_err = ERR_DIGITS;
         else if (sized_n && size_n == '0)                      fin_err = ERR_ZERO;
      end
      if (!sized_n || int'(size_n) >= VAL_W) size_mask = '1;
      else size_mask = {VAL_W{1'b1}} >> (VAL_W - int'(size_n));
      pre_val    = acc_n & size_mask;
      size_trunc = |(acc_n & ~size_mask);
   end

   sv_lit_cast #(.VAL_W(VAL_W)) u_cast (
      .value     (pre_val),
      .type_code (type_n),
      .result    (cast_val),
      .trunc     (cast_trunc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE; acc <= '0; size_q <= '0; sized_q <= 1'b0; base_q <= BASE_DEC;
         err_q <= ERR_NONE; dig_q <= 1'b0; sgn_q <= 1'b0; type_q <= TYPE_IMPLICIT;
         in_ready <= 1'b0; out_valid <= 1'b0; out_value <= '0; out_size <= '0;
         out_base <= '0; out_trunc <= 1'b0; out_err <= '0;
      end else if (state == ST_OUT) begin
         if (out_ready) begin
            state <= ST_IDLE; out_valid <= 1'b0; in_ready <= 1'b1;
         end
      end else begin
         in_ready <= 1'b1;
         if (accept) begin
            state <= st_n; acc <= acc_n; size_q <= size_n; sized_q <= sized_n;
            base_q <= base_n; err_q <= err_n; dig_q <= dig_n; sgn_q <= sgn_n; type_q <= type_n;
            if (in_last) begin
               state     <= ST_OUT;
               in_ready  <= 1'b0;
               out_valid <= 1'b1;
               out_value <= (fin_err != ERR_NONE) ? '0 : cast_val;
               out_trunc <= (fin_err == ERR_NONE) && (size_trunc || cast_trunc);
               out_size  <= size_n;
               out_base  <= base_n;
               out_err   <= fin_err;
            end
         end
      end
   end

endmodule

// File: tb/tb_sv_literal_parser.sv
// Directed bench for sv_literal_parser: literal tokens streamed byte-wise, results checked inline.
module tb_sv_literal_parser;
   import sv_lit_pkg::*;

   localparam int VAL_W  = 64;
   localparam int SIZE_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0, in_ready, in_last = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic [3:0]        type_code = 4'd0;
   logic              out_valid, out_ready = 1'b0, out_trunc;
   logic [VAL_W-1:0]  out_value;
   logic [SIZE_W-1:0] out_size;
   logic [1:0]        out_base;
   logic [2:0]        out_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [VAL_W-1:0]  r_value;
   logic [SIZE_W-1:0] r_size;
   logic [1:0]        r_base;
   logic              r_trunc;
   logic [2:0]        r_err;

   sv_literal_parser #(.VAL_W(VAL_W), .SIZE_W(SIZE_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .type_code(type_code), .out_valid(out_valid), .out_ready(out_ready),
      .out_value(out_value), .out_size(out_size), .out_base(out_base), .out_trunc(out_trunc),
      .out_err(out_err)
   );

   always #5 clk = ~clk;

   // Called just after a rising edge; the byte is taken on the next edge.
   task automatic send_byte(input logic [7:0] c, input logic last);
      int n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      n_checks++;
      if (!in_ready) begin n_fail++; $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready); end
      in_valid = 1'b1; in_data = c; in_last = last;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
   endtask

   task automatic send_token(input string s, input logic with_last);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], with_last && (i == s.len() - 1));
   endtask

   task automatic collect();
      int n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      n_checks++;
      if (!out_valid) begin n_fail++; $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid); end
      r_value = out_value; r_size = out_size; r_base = out_base; r_trunc = out_trunc; r_err = out_err;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0 || out_value !== '0 || out_err !== 3'd0 || out_size !== '0)
         begin n_fail++; $display("FAIL reset_outputs: valid=%b value=%0h err=%0d size=%0d want all 0", out_valid, out_value, out_err, out_size); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_hex_int();
      type_code = TYPE_INT;
      send_token("32'h", 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL h8_early_valid: got %b want 0", out_valid); end
      send_byte("8", 1'b1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL h8_latency: out_valid=%b want 1", out_valid); end
      collect();
      n_checks++; if (r_value !== 64'd8) begin n_fail++; $display("FAIL h8_value: got %0h want 8", r_value); end
      n_checks++; if (r_size !== 16'd32 || r_base !== 2'd3) begin n_fail++; $display("FAIL h8_size_base: got %0d/%0d want 32/3", r_size, r_base); end
      n_checks++; if (r_trunc !== 1'b0 || r_err !== 3'd0) begin n_fail++; $display("FAIL h8_flags: trunc=%b err=%0d want 0/0", r_trunc, r_err); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL h8_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_cast_bit();
      type_code = TYPE_BIT;
      send_token("2", 1'b1);
      collect();
      n_checks++; if (r_value !== 64'd0 || r_trunc !== 1'b1) begin n_fail++; $display("FAIL bit_cast: value=%0h trunc=%b want 0/1", r_value, r_trunc); end
      n_checks++; if (r_size !== 16'd0 || r_base !== 2'd0 || r_err !== 3'd0) begin n_fail++; $display("FAIL bit_meta: size=%0d base=%0d err=%0d want 0/0/0", r_size, r_base, r_err); end
   endtask

   task automatic test_stall();
      type_code = TYPE_BYTE;
      send_token("32'o5", 1'b1);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_value !== 64'd5 || out_base !== 2'd2)
            begin n_fail++; $display("FAIL stall_hold%0d: valid=%b ready=%b value=%0h base=%0d want 1/0/5/2", i, out_valid, in_ready, out_value, out_base); end
         @(posedge clk); #1;
      end
      collect();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_after: got %b want 1", in_ready); end
      n_checks++; if (r_value !== 64'd5 || r_size !== 16'd32 || r_trunc !== 1'b0) begin n_fail++; $display("FAIL stall_result: value=%0h size=%0d trunc=%b want 5/32/0", r_value, r_size, r_trunc); end
   endtask

   task automatic test_sign_extend();
      type_code = TYPE_BYTE;
      send_token("8'hFF", 1'b1);
      collect();
      n_checks++; if (r_value !== 64'hFFFF_FFFF_FFFF_FFFF || r_trunc !== 1'b0) begin n_fail++; $display("FAIL byte_sext: value=%0h trunc=%b want ffffffffffffffff/0", r_value, r_trunc); end
      type_code = TYPE_IMPLICIT;
      send_token("4'hFF", 1'b1);
      collect();
      n_checks++; if (r_value !== 64'hF || r_trunc !== 1'b1 || r_size !== 16'd4) begin n_fail++; $display("FAIL size_mask: value=%0h trunc=%b size=%0d want f/1/4", r_value, r_trunc, r_size); end
   endtask

   task automatic test_errors();
      string      tok[4];
      logic [2:0] exp_err[4];
      string      nines = "";
      for (int i = 0; i < 21; i++) nines = {nines, "9"};
      tok[0] = "32'";   exp_err[0] = 3'd2;
      tok[1] = "32'q1"; exp_err[1] = 3'd1;
      tok[2] = "0'b1";  exp_err[2] = 3'd3;
      tok[3] = nines;   exp_err[3] = 3'd4;
      type_code = TYPE_IMPLICIT;
      for (int i = 0; i < 4; i++) begin
         send_token(tok[i], 1'b1);
         collect();
         n_checks++;
         if (r_err !== exp_err[i] || r_value !== '0)
            begin n_fail++; $display("FAIL err_case%0d: err=%0d value=%0h want %0d/0", i, r_err, r_value, exp_err[i]); end
      end
   endtask

   task automatic test_reset_mid_token();
      type_code = TYPE_TIME;
      send_token("32'", 1'b0);
      rst_n = 1'b0;
      #3;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset: valid=%b ready=%b want 0/0", out_valid, in_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send_token("32'b1", 1'b1);
      collect();
      n_checks++; if (r_value !== 64'd1 || r_err !== 3'd0) begin n_fail++; $display("FAIL midreset_value: value=%0h err=%0d want 1/0", r_value, r_err); end
      n_checks++; if (r_size !== 16'd32 || r_base !== 2'd1) begin n_fail++; $display("FAIL midreset_meta: size=%0d base=%0d want 32/1", r_size, r_base); end
   endtask

   task automatic test_back_to_back();
      type_code = TYPE_IMPLICIT;
      send_token("'hAb_c", 1'b1);
      collect();
      n_checks++; if (r_value !== 64'hABC || r_size !== 16'd0 || r_base !== 2'd3) begin n_fail++; $display("FAIL unsized_hex: value=%0h size=%0d base=%0d want abc/0/3", r_value, r_size, r_base); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
      type_code = TYPE_INTEGER;
      send_token("7'd100", 1'b1);
      collect();
      n_checks++; if (r_value !== 64'd100 || r_size !== 16'd7 || r_trunc !== 1'b0) begin n_fail++; $display("FAIL dec_sized: value=%0d size=%0d trunc=%b want 100/7/0", r_value, r_size, r_trunc); end
      type_code = TYPE_SHORTINT;
      send_token("16'sd255", 1'b1);
      collect();
      n_checks++; if (r_value !== 64'd255 || r_base !== 2'd0 || r_err !== 3'd0) begin n_fail++; $display("FAIL signed_dec: value=%0d base=%0d err=%0d want 255/0/0", r_value, r_base, r_err); end
   endtask

   initial begin
      test_reset();
      test_hex_int();
      test_cast_bit();
      test_stall();
      test_sign_extend();
      test_errors();
      test_reset_mid_token();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
